// File: rtl/fwd_hazard_unit.sv
// EX-stage forward selects and decode stall from EX/MEM/WB slots plus a per-register mul scoreboard.
// Outputs are combinational (zero latency); stall is the only back-pressure, holding decode while EX takes a bubble.
module fwd_hazard_unit #(
  parameter int REG_AW   = 5,
  parameter int MUL_LAT  = 4,
  parameter int MUL_PIPE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_is_store,
  input  logic              id_is_load,
  input  logic              id_is_mul,
  input  logic              id_wr,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              flush,
  output logic              stall,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [1:0]        fwd_st,
  output logic              mul_busy
);

  localparam int   NREGS      = 2 ** REG_AW;
  localparam int   CW         = $clog2(MUL_LAT + 1);
  localparam logic SERIAL_MUL = (MUL_PIPE == 0);

  typedef struct packed {
    logic              valid;
    logic              wr;
    logic              load;
    logic              store;
    logic              use_rs;
    logic              use_rt;
    logic [REG_AW-1:0] dest;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
  } ex_slot_t;

  // Downstream slots only keep what forwarding compares against.
  typedef struct packed {
    logic              valid;
    logic              wr;
    logic              load;
    logic [REG_AW-1:0] dest;
  } mem_slot_t;

  typedef struct packed {
    logic              valid;
    logic              wr;
    logic [REG_AW-1:0] dest;
  } wb_slot_t;

  ex_slot_t         r_ex;
  mem_slot_t        r_mem;
  wb_slot_t         r_wb;
  logic [CW-1:0]    r_cnt [NREGS];

  ex_slot_t         w_id_slot;
  logic             w_rt_used;
  logic             w_busy;
  logic             w_load_use;
  logic             w_mul_stall;
  logic             w_stall;
  logic             w_issue;
  logic             w_mul_issue;
  logic             w_set;

  function automatic logic [1:0] fwd_src(input logic [REG_AW-1:0] s,
                                         input mem_slot_t m,
                                         input wb_slot_t w);
    logic [1:0] sel;
    sel = 2'd0;
    if (s != '0) begin
      if (m.valid && m.wr && !m.load && m.dest == s) sel = 2'd1;
      else if (w.valid && w.wr && w.dest == s)      sel = 2'd2;
    end
    return sel;
  endfunction

  assign w_id_slot = '{valid: 1'b1, wr: id_wr, load: id_is_load, store: id_is_store,
                       use_rs: id_use_rs, use_rt: id_use_rt,
                       dest: id_dest, rs: id_rs, rt: id_rt};

  assign w_rt_used = id_use_rt | id_is_store;

  always_comb begin
    w_busy = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (r_cnt[i] != '0) w_busy = 1'b1;
    end
  end

  assign w_load_use  = r_ex.valid & r_ex.load & (r_ex.dest != '0) &
                       ((id_use_rs & (r_ex.dest == id_rs)) |
                        (w_rt_used & (r_ex.dest == id_rt)));
  assign w_mul_stall = (id_use_rs & (r_cnt[id_rs] != '0)) |
                       (w_rt_used & (r_cnt[id_rt] != '0)) |
                       (id_wr & (r_cnt[id_dest] != '0)) |
                       (id_is_mul & SERIAL_MUL & w_busy);
  assign w_stall     = id_valid & ~flush & (w_load_use | w_mul_stall);
  assign w_issue     = id_valid & ~w_stall & ~flush;
  assign w_mul_issue = w_issue & id_is_mul;
  assign w_set       = w_mul_issue & id_wr & (id_dest != '0);

  always_comb begin
    stall    = w_stall;
    mul_busy = w_busy;
    fwd_a    = 2'd0;
    fwd_b    = 2'd0;
    fwd_st   = 2'd0;
    if (r_ex.valid && r_ex.use_rs) fwd_a  = fwd_src(r_ex.rs, r_mem, r_wb);
    if (r_ex.valid && r_ex.use_rt) fwd_b  = fwd_src(r_ex.rt, r_mem, r_wb);
    if (r_ex.valid && r_ex.store)  fwd_st = fwd_src(r_ex.rt, r_mem, r_wb);
  end

  // Muls bypass the EX/MEM/WB slots entirely; their result is tracked only by the scoreboard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_ex  <= (w_issue && !id_is_mul) ? w_id_slot : '0;
      r_mem <= '{valid: r_ex.valid, wr: r_ex.wr, load: r_ex.load, dest: r_ex.dest};
      r_wb  <= '{valid: r_mem.valid, wr: r_mem.wr, dest: r_mem.dest};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (w_set && id_dest == REG_AW'(i)) r_cnt[i] <= CW'(MUL_LAT);
        else if (r_cnt[i] != '0)           r_cnt[i] <= r_cnt[i] - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed pipeline scenarios then random instruction streams,
// checked against a cycle-indexed issue history and mul completion times.
module tb_fwd_hazard_unit;

  localparam int AW  = 5;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, id_use_rs, id_use_rt, id_is_store, id_is_load, id_is_mul, id_wr, flush;
  logic [AW-1:0] id_rs, id_rt, id_dest;
  logic          stall, mul_busy, p_stall, p_mul_busy;
  logic [1:0]    fwd_a, fwd_b, fwd_st, p_fwd_a, p_fwd_b, p_fwd_st;

  fwd_hazard_unit #(.REG_AW(AW), .MUL_LAT(LAT), .MUL_PIPE(0)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_is_store(id_is_store),
    .id_is_load(id_is_load), .id_is_mul(id_is_mul), .id_wr(id_wr), .id_dest(id_dest),
    .flush(flush), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_st(fwd_st),
    .mul_busy(mul_busy));

  fwd_hazard_unit #(.REG_AW(AW), .MUL_LAT(LAT), .MUL_PIPE(1)) dut_p (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_is_store(id_is_store),
    .id_is_load(id_is_load), .id_is_mul(id_is_mul), .id_wr(id_wr), .id_dest(id_dest),
    .flush(flush), .stall(p_stall), .fwd_a(p_fwd_a), .fwd_b(p_fwd_b), .fwd_st(p_fwd_st),
    .mul_busy(p_mul_busy));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    bit v, wr, ld, st, urs, urt;
    int rs, rt, dest;
  } ins_t;

  // rec[c % 8] holds the non-mul instruction issued in cycle c; done_at[r] is the first cycle r is free.
  ins_t rec [8];
  int   done_at [32];
  int   cyc;
  bit   e_stall, e_busy;
  int   e_fa, e_fb, e_fst;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit busy(input int r);
    return (r != 0) && (cyc < done_at[r]);
  endfunction

  function automatic int fsel(input int s, input ins_t m, input ins_t w);
    if (s == 0) return 0;
    if (m.v && m.wr && !m.ld && m.dest == s) return 1;
    if (w.v && w.wr && w.dest == s) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) rec[i].v = 1'b0;
    for (int i = 0; i < 32; i++) done_at[i] = 0;
  endtask

  task automatic model_eval();
    ins_t ex, mem, wb;
    bit any, lu, ms, rt_used;
    ex  = rec[(cyc - 1) % 8];
    mem = rec[(cyc - 2) % 8];
    wb  = rec[(cyc - 3) % 8];
    any = 1'b0;
    for (int r = 1; r < 32; r++) if (busy(r)) any = 1'b1;
    rt_used = id_use_rt || id_is_store;
    lu = ex.v && ex.ld && ex.dest != 0 &&
         ((id_use_rs && ex.dest == int'(id_rs)) || (rt_used && ex.dest == int'(id_rt)));
    ms = (id_use_rs && busy(int'(id_rs))) || (rt_used && busy(int'(id_rt))) ||
         (id_wr && busy(int'(id_dest))) || (id_is_mul && any);
    e_stall = id_valid && !flush && (lu || ms);
    e_fa    = (ex.v && ex.urs) ? fsel(ex.rs, mem, wb) : 0;
    e_fb    = (ex.v && ex.urt) ? fsel(ex.rt, mem, wb) : 0;
    e_fst   = (ex.v && ex.st)  ? fsel(ex.rt, mem, wb) : 0;
    e_busy  = any;
  endtask

  task automatic mid();
    @(negedge clk);
    model_eval();
    chk("stall", {7'd0, stall}, {7'd0, e_stall});
    chk("fwd_a", {6'd0, fwd_a}, 8'(e_fa));
    chk("fwd_b", {6'd0, fwd_b}, 8'(e_fb));
    chk("fwd_st", {6'd0, fwd_st}, 8'(e_fst));
    chk("mul_busy", {7'd0, mul_busy}, {7'd0, e_busy});
  endtask

  task automatic adv();
    ins_t i;
    bit issue;
    issue  = id_valid && !e_stall && !flush;
    i.v    = issue && !id_is_mul;
    i.wr   = id_wr;   i.ld  = id_is_load; i.st  = id_is_store;
    i.urs  = id_use_rs; i.urt = id_use_rt;
    i.rs   = int'(id_rs); i.rt = int'(id_rt); i.dest = int'(id_dest);
    rec[cyc % 8] = i;
    if (issue && id_is_mul && id_wr && id_dest != 0) done_at[id_dest] = cyc + LAT + 1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_in(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                        input bit st, input bit ld, input bit mul, input bit wr, input int dest);
    id_valid = v; id_rs = rs[AW-1:0]; id_rt = rt[AW-1:0];
    id_use_rs = urs; id_use_rt = urt; id_is_store = st; id_is_load = ld;
    id_is_mul = mul; id_wr = wr; id_dest = dest[AW-1:0]; flush = 1'b0;
  endtask

  task automatic i_nop();                            set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  endtask
  task automatic i_alu(input int d, rs, rt);        set_in(1, rs, rt, 1, 1, 0, 0, 0, 1, d); endtask
  task automatic i_ld(input int d, rs);             set_in(1, rs, 0, 1, 0, 0, 1, 0, 1, d);  endtask
  task automatic i_st(input int rs, rt);            set_in(1, rs, rt, 1, 0, 1, 0, 0, 0, 0); endtask
  task automatic i_mul(input int d, rs, rt);        set_in(1, rs, rt, 1, 1, 0, 0, 1, 1, d); endtask

  task automatic idle(input int k);
    repeat (k) begin i_nop(); mid(); adv(); end
  endtask

  initial begin
    rst_n = 1'b0;
    i_nop();
    model_reset();
    cyc = 8;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {7'd0, stall}, 8'd0);
    chk("rst_fwd", {2'd0, fwd_a, fwd_b, fwd_st}, 8'd0);
    chk("rst_busy", {7'd0, mul_busy}, 8'd0);
    chk("rst_p_busy", {7'd0, p_mul_busy}, 8'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // add r3,r1,r2 ; sub r4,r3,r5
    i_alu(3, 1, 2); mid(); adv();
    i_alu(4, 3, 5); mid(); chk("t1_stall", {7'd0, stall}, 8'd0); adv();
    i_nop(); mid(); chk("t1_fwd_a", {6'd0, fwd_a}, 8'd1); chk("t1_fwd_b", {6'd0, fwd_b}, 8'd0); adv();
    idle(3);

    // add r3 ; nop ; sw r3,0(r6)
    i_alu(3, 1, 2); mid(); adv();
    i_nop(); mid(); adv();
    i_st(6, 3); mid(); adv();
    i_nop(); mid();
    chk("t2_fwd_st", {6'd0, fwd_st}, 8'd2);
    chk("t2_fwd_a", {6'd0, fwd_a}, 8'd0);
    chk("t2_fwd_b", {6'd0, fwd_b}, 8'd0);
    adv();
    idle(3);

    // lw r7 ; add r8,r7,r7
    i_ld(7, 1); mid(); adv();
    i_alu(8, 7, 7); mid(); chk("t3_stall1", {7'd0, stall}, 8'd1); adv();
    mid(); chk("t3_stall2", {7'd0, stall}, 8'd0); adv();
    i_nop(); mid();
    chk("t3_fwd_a", {6'd0, fwd_a}, 8'd2);
    chk("t3_fwd_b", {6'd0, fwd_b}, 8'd2);
    adv();
    idle(3);

    // mul r9 ; add r10,r9,r1
    i_mul(9, 1, 2); mid(); adv();
    i_alu(10, 9, 1);
    for (int k = 0; k < LAT; k++) begin
      mid(); chk("t4_stall_hi", {7'd0, stall}, 8'd1); chk("t4_busy", {7'd0, mul_busy}, 8'd1); adv();
    end
    mid(); chk("t4_stall_lo", {7'd0, stall}, 8'd0); chk("t4_busy_lo", {7'd0, mul_busy}, 8'd0); adv();
    i_nop(); mid(); chk("t4_fwd_a", {6'd0, fwd_a}, 8'd0); adv();
    idle(3);

    // mul r9 ; mul r11 on serial and pipelined instances
    i_mul(9, 1, 2); mid(); adv();
    i_mul(11, 3, 4); mid();
    chk("t5_p_stall", {7'd0, p_stall}, 8'd0);
    chk("t5_p_busy", {7'd0, p_mul_busy}, 8'd1);
    chk("t5_stall_1", {7'd0, stall}, 8'd1);
    adv();
    for (int k = 1; k < LAT; k++) begin mid(); chk("t5_stall_n", {7'd0, stall}, 8'd1); adv(); end
    mid(); chk("t5_stall_lo", {7'd0, stall}, 8'd0); adv();
    idle(LAT + 2);

    // r0 never forwards
    i_alu(0, 1, 2); mid(); adv();
    i_alu(2, 0, 0); mid(); chk("t6_r0_stall", {7'd0, stall}, 8'd0); adv();
    i_nop(); mid();
    chk("t6_r0_fwd_a", {6'd0, fwd_a}, 8'd0);
    chk("t6_r0_fwd_b", {6'd0, fwd_b}, 8'd0);
    adv();
    idle(3);

    // flush with lw in EX and dependent in decode
    i_ld(7, 1); mid(); adv();
    i_alu(8, 7, 7); flush = 1'b1; mid(); chk("t6_flush_stall", {7'd0, stall}, 8'd0); adv();
    idle(4);

    // reset in the middle of a multiply
    i_mul(9, 1, 2); mid(); adv();
    i_alu(10, 9, 1); mid(); chk("t6_busy_pre", {7'd0, mul_busy}, 8'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", {7'd0, mul_busy}, 8'd0);
    chk("t6_rst_stall", {7'd0, stall}, 8'd0);
    chk("t6_rst_p_busy", {7'd0, p_mul_busy}, 8'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc++;
    mid(); chk("t6_post_stall", {7'd0, stall}, 8'd0); adv();
    idle(3);

    // random instruction stream; a stalled instruction is usually held in decode
    for (int k = 0; k < 600; k++) begin
      if (!(e_stall && $urandom_range(3) != 0)) begin
        int kind, d, a, b;
        kind = $urandom_range(9);
        d = $urandom_range(7); a = $urandom_range(7); b = $urandom_range(7);
        case (kind)
          0, 1:    i_ld(d, a);
          2:       i_st(a, b);
          3, 4:    i_mul(d, a, b);
          5:       set_in(1, a, b, 1, 0, 0, 0, 0, 1, d);
          default: i_alu(d, a, b);
        endcase
        if ($urandom_range(7) == 0) id_valid = 1'b0;
      end
      mid();
      adv();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
